ctx_mem_responder: RTL and testbench
====================================

CTX_MEM_RESPONDER -- requirements
Module: ctx_mem_responder

Interface
REQ-001 Param BASE_ADDR, default 32'h0001_0000, byte address of word 0 of the context store.
REQ-002 Param DEPTH, default 1024, number of 32-bit words; power of two, 16..65536.
REQ-003 Param LATENCY, default 2, read-response latency in cycles; legal range 1..8.
REQ-004 Param ERR_DATA, default 32'hDEAD_BEEF, data returned for out-of-range reads.
REQ-005 clk_i  in  1  single clock, all state on the rising edge.
REQ-006 rst_ni  in  1  reset, synchronous, active-low.
REQ-007 ctx_mem_wr_en_i  in  1  write request strobe, one word per cycle.
REQ-008 ctx_mem_wr_addr_i  in  32  write byte address.
REQ-009 ctx_mem_wr_data_i  in  32  write data.
REQ-010 ctx_mem_rd_rq_valid_i  in  1  read request strobe, one request per cycle.
REQ-011 ctx_mem_rd_rq_addr_i  in  32  read byte address.
REQ-012 ctx_mem_rd_resp_valid_o  out  1  read response valid, one-cycle pulse per request.
REQ-013 ctx_mem_rd_data_o  out  32  read response data.
REQ-014 outstanding_o  out  4  reads accepted but not yet responded.
REQ-015 err_o  out  1  one-cycle pulse for each out-of-range access.
REQ-016 err_count_o  out  16  saturating count of out-of-range accesses.

Function
REQ-017 No backpressure: the block SHALL accept every asserted write and read strobe in the cycle it is sampled.
REQ-018 Word index = (addr - BASE_ADDR) >> 2; addr[1:0] SHALL be ignored.
REQ-019 An address is in range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH, with the compare done in 33-bit arithmetic so there is no wrap at 2^32.
REQ-020 An in-range write accepted at edge T SHALL update the store at edge T; out-of-range writes SHALL be dropped.
REQ-021 A read accepted at edge T SHALL produce ctx_mem_rd_resp_valid_o=1 during exactly the cycle after edge T+LATENCY-1 (LATENCY cycles after acceptance).
REQ-022 Read data SHALL be captured at acceptance; later writes to the same word SHALL NOT alter an in-flight response.
REQ-023 If a write and a read to the same word are accepted at the same edge, the response SHALL return the new write data (write-forwarding).
REQ-024 Back-to-back reads SHALL return in order, one response per cycle, with no bubbles.
REQ-025 An out-of-range read SHALL still respond at the normal latency, with data ERR_DATA.
REQ-026 When ctx_mem_rd_resp_valid_o=0, ctx_mem_rd_data_o SHALL be 32'h0.
REQ-027 outstanding_o SHALL increment on accept and decrement on response; if both occur in the same cycle it SHALL be unchanged; its maximum value is LATENCY.
REQ-028 err_o SHALL pulse the cycle after an out-of-range access.
REQ-029 err_count_o SHALL add 1 per offending strobe, or 2 when an out-of-range write and an out-of-range read occur in the same cycle, and SHALL saturate at 16'hFFFF.

Reset
REQ-030 While rst_ni=0 at an edge, the following SHALL be cleared: ctx_mem_rd_resp_valid_o=0, ctx_mem_rd_data_o=0, outstanding_o=0, err_o=0, err_count_o=0, and all in-flight pipeline stages.
REQ-031 Reads in flight when reset asserts SHALL never produce a response.
REQ-032 Store contents SHALL NOT be reset and SHALL persist across reset.
REQ-033 Strobes sampled while rst_ni=0 SHALL be ignored, including writes.

Structure
REQ-034 Package ctx_mem_pkg SHALL hold the ctx_word_t typedef (32 bits), the default ERR_DATA constant, the MAX_LATENCY=8 constant, and an in_range address-decode function.
REQ-035 Sub-module ctx_mem_resp_pipe SHALL implement the LATENCY-deep valid/data delay line.
REQ-036 The store is a plain register array or inferred RAM with a combinational read at acceptance; forwarding muxes in front of the pipe.

Verification
REQ-037 Read of the reset-state store: write 0x1234_5678 to 0x0001_0040, then read 0x0001_0040 at T -> resp_valid at T+2, data 0x1234_5678.
REQ-038 Four back-to-back reads of 0x0001_0000..0x0001_000C at T..T+3 -> responses at T+2..T+5 in order, outstanding_o peaks at 2.
REQ-039 Same-edge write 0xCAFE_0001 and read of 0x0001_0010 -> response 0xCAFE_0001; a write to the same address one cycle after the read -> response unaffected.
REQ-040 Out-of-range cases:
- Read 0x0000_FFFC -> data 0xDEAD_BEEF at normal latency, err_o pulse, err_count_o=1.
- Write 0x0001_1000 -> dropped, err_count_o=2.
REQ-041 With LATENCY=4, reset asserted at T+1 after a read at T -> no response at T+4, outstanding_o=0, and previously written data still reads back after reset.

Source files
------------

// File: rtl/ctx_mem_pkg.sv
// Shared types, constants and address decode for the context-memory responder.
package ctx_mem_pkg;

    typedef logic [31:0] ctx_word_t;

    localparam ctx_word_t   ERR_DATA_DEFAULT = 32'hDEAD_BEEF;
    localparam int unsigned MAX_LATENCY      = 8;

    // 33-bit compare so a window ending at 2^32 does not wrap.
    function automatic logic in_range(input ctx_word_t addr, input ctx_word_t base,
                                      input int unsigned depth);
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + (33'(depth) << 2);
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/ctx_mem_resp_pipe.sv
// LATENCY-deep valid/data delay line for read responses; data is zero when not valid.
module ctx_mem_resp_pipe
    import ctx_mem_pkg::*;
#(
    parameter int unsigned LATENCY = 2
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      in_valid_i,
    input  ctx_word_t in_data_i,
    output logic      out_valid_o,
    output ctx_word_t out_data_o
);

    logic      valid_q [LATENCY];
    ctx_word_t data_q  [LATENCY];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                valid_q[i] <= 1'b0;
                data_q[i]  <= '0;
            end
        end else begin
            valid_q[0] <= in_valid_i;
            data_q[0]  <= in_valid_i ? in_data_i : '0;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign out_valid_o = valid_q[LATENCY-1];
    assign out_data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/ctx_mem_responder.sv
// Word-addressed context store with fixed-latency read responses, write forwarding
// and out-of-range error reporting.
module ctx_mem_responder
    import ctx_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] ERR_DATA  = ERR_DATA_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ctx_mem_wr_en_i,
    input  logic [31:0] ctx_mem_wr_addr_i,
    input  logic [31:0] ctx_mem_wr_data_i,
    input  logic        ctx_mem_rd_rq_valid_i,
    input  logic [31:0] ctx_mem_rd_rq_addr_i,
    output logic        ctx_mem_rd_resp_valid_o,
    output logic [31:0] ctx_mem_rd_data_o,
    output logic [3:0]  outstanding_o,
    output logic        err_o,
    output logic [15:0] err_count_o
);

    localparam int unsigned IdxW = $clog2(DEPTH);

    ctx_word_t        mem_q [DEPTH];
    ctx_word_t        wr_off, rd_off, rd_word;
    logic [IdxW-1:0]  wr_idx, rd_idx;
    logic             wr_ok, wr_oor, rd_acc, rd_ok, rd_oor;
    logic             resp_valid;
    ctx_word_t        resp_data;
    logic [3:0]       outstanding_q;
    logic             err_q;
    logic [15:0]      err_count_q;
    logic [16:0]      err_sum;

    // Strobes are gated by reset so nothing is accepted while rst_ni is low.
    always_comb begin
        wr_off  = ctx_mem_wr_addr_i - BASE_ADDR;
        rd_off  = ctx_mem_rd_rq_addr_i - BASE_ADDR;
        wr_idx  = wr_off[IdxW+1:2];
        rd_idx  = rd_off[IdxW+1:2];
        wr_ok   = rst_ni && ctx_mem_wr_en_i && in_range(ctx_mem_wr_addr_i, BASE_ADDR, DEPTH);
        wr_oor  = rst_ni && ctx_mem_wr_en_i && !in_range(ctx_mem_wr_addr_i, BASE_ADDR, DEPTH);
        rd_acc  = rst_ni && ctx_mem_rd_rq_valid_i;
        rd_ok   = rd_acc && in_range(ctx_mem_rd_rq_addr_i, BASE_ADDR, DEPTH);
        rd_oor  = rd_acc && !rd_ok;
        if (!rd_ok) begin
            rd_word = ERR_DATA;
        end else if (wr_ok && (wr_idx == rd_idx)) begin
            rd_word = ctx_mem_wr_data_i;
        end else begin
            rd_word = mem_q[rd_idx];
        end
        err_sum = {1'b0, err_count_q} + 17'(wr_oor) + 17'(rd_oor);
    end

    // Store is deliberately not reset; contents survive rst_ni.
    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem_q[wr_idx] <= ctx_mem_wr_data_i;
        end
    end

    ctx_mem_resp_pipe #(
        .LATENCY(LATENCY)
    ) u_pipe (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .in_valid_i (rd_acc),
        .in_data_i  (rd_word),
        .out_valid_o(resp_valid),
        .out_data_o (resp_data)
    );

    // A response counts as delivered at the edge that ends its valid cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
            err_q         <= 1'b0;
            err_count_q   <= '0;
        end else begin
            outstanding_q <= outstanding_q + 4'(rd_acc) - 4'(resp_valid);
            err_q         <= wr_oor | rd_oor;
            err_count_q   <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    assign ctx_mem_rd_resp_valid_o = resp_valid;
    assign ctx_mem_rd_data_o       = resp_data;
    assign outstanding_o           = outstanding_q;
    assign err_o                   = err_q;
    assign err_count_o             = err_count_q;

endmodule

// File: tb/tb_ctx_mem_responder.sv
// Directed scoreboard bench: one LATENCY=2 instance and one LATENCY=4 instance.
module tb_ctx_mem_responder;

    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        wr_en2, rd_v2, wr_en4, rd_v4;
    logic [31:0] wr_addr2, wr_data2, rd_addr2, wr_addr4, wr_data4, rd_addr4;
    logic        rv2, err2, rv4, err4;
    logic [31:0] rd2, rd4;
    logic [3:0]  outst2, outst4;
    logic [15:0] errc2, errc4;

    ctx_mem_responder #(.LATENCY(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n),
        .ctx_mem_wr_en_i(wr_en2), .ctx_mem_wr_addr_i(wr_addr2), .ctx_mem_wr_data_i(wr_data2),
        .ctx_mem_rd_rq_valid_i(rd_v2), .ctx_mem_rd_rq_addr_i(rd_addr2),
        .ctx_mem_rd_resp_valid_o(rv2), .ctx_mem_rd_data_o(rd2),
        .outstanding_o(outst2), .err_o(err2), .err_count_o(errc2)
    );

    ctx_mem_responder #(.LATENCY(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n),
        .ctx_mem_wr_en_i(wr_en4), .ctx_mem_wr_addr_i(wr_addr4), .ctx_mem_wr_data_i(wr_data4),
        .ctx_mem_rd_rq_valid_i(rd_v4), .ctx_mem_rd_rq_addr_i(rd_addr4),
        .ctx_mem_rd_resp_valid_o(rv4), .ctx_mem_rd_data_o(rd4),
        .outstanding_o(outst4), .err_o(err4), .err_count_o(errc4)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        q2[$], q4[$];
    exp_t        h2, h4;
    logic [31:0] mdl2 [int];
    logic [31:0] mdl4 [int];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          peak2 = 0;
    bit          mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + 4096);
    endfunction

    function automatic int idx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    task automatic wr2(input logic [31:0] a, input logic [31:0] d);
        wr_en2 = 1'b1; wr_addr2 = a; wr_data2 = d;
        if (in_rng(a)) mdl2[idx(a)] = d;
    endtask

    task automatic rd2_op(input logic [31:0] a);
        exp_t e;
        rd_v2 = 1'b1; rd_addr2 = a;
        e.data = in_rng(a) ? mdl2[idx(a)] : ERRD;
        e.due  = cyc + 2;
        q2.push_back(e);
    endtask

    task automatic wr4(input logic [31:0] a, input logic [31:0] d);
        wr_en4 = 1'b1; wr_addr4 = a; wr_data4 = d;
        if (in_rng(a)) mdl4[idx(a)] = d;
    endtask

    task automatic rd4_op(input logic [31:0] a);
        exp_t e;
        rd_v4 = 1'b1; rd_addr4 = a;
        e.data = in_rng(a) ? mdl4[idx(a)] : ERRD;
        e.due  = cyc + 4;
        q4.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        wr_en2 = 1'b0; rd_v2 = 1'b0; wr_en4 = 1'b0; rd_v4 = 1'b0;
    endtask

    // Response monitor: pops the scoreboard on every valid and checks data and arrival cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rv2) begin
                if (q2.size() == 0) check("dut2 unexpected resp", 32'(rv2), 32'd0);
                else begin
                    h2 = q2.pop_front();
                    check("dut2 resp data", rd2, h2.data);
                    check("dut2 resp cycle", cyc, h2.due);
                end
            end else check("dut2 idle data", rd2, 32'd0);
            if (q2.size() > 0 && q2[0].due < cyc) begin
                check("dut2 missing resp", cyc, q2[0].due);
                void'(q2.pop_front());
            end
            if (rv4) begin
                if (q4.size() == 0) check("dut4 unexpected resp", 32'(rv4), 32'd0);
                else begin
                    h4 = q4.pop_front();
                    check("dut4 resp data", rd4, h4.data);
                    check("dut4 resp cycle", cyc, h4.due);
                end
            end else check("dut4 idle data", rd4, 32'd0);
            if (q4.size() > 0 && q4[0].due < cyc) begin
                check("dut4 missing resp", cyc, q4[0].due);
                void'(q4.pop_front());
            end
            if (int'(outst2) > peak2) peak2 = int'(outst2);
        end
    end

    initial begin
        rst_n = 1'b0;
        wr_en2 = 1'b0; rd_v2 = 1'b0; wr_addr2 = '0; wr_data2 = '0; rd_addr2 = '0;
        wr_en4 = 1'b0; rd_v4 = 1'b0; wr_addr4 = '0; wr_data4 = '0; rd_addr4 = '0;
        repeat (3) tick();
        check("reset resp_valid", 32'(rv2), 32'd0);
        check("reset rd_data", rd2, 32'd0);
        check("reset outstanding", 32'(outst2), 32'd0);
        check("reset err", 32'(err2), 32'd0);
        check("reset err_count", 32'(errc2), 32'd0);
        check("reset dut4 outstanding", 32'(outst4), 32'd0);
        mon_en = 1'b1;
        rst_n  = 1'b1;

        // Basic write then read.
        wr2(32'h0001_0040, 32'h1234_5678); tick();
        rd2_op(32'h0001_0040); tick();
        for (int i = 0; i < 4; i++) begin
            wr2(BASE + 32'(4 * i), 32'h1000_0000 + 32'(i)); tick();
        end
        wr2(32'h0001_0FFC, 32'h0FFC_0FFC); tick();
        repeat (3) tick();

        // Back-to-back reads.
        peak2 = 0;
        for (int i = 0; i < 4; i++) begin
            rd2_op(BASE + 32'(4 * i)); tick();
        end
        repeat (4) tick();
        check("outstanding peak", 32'(peak2), 32'd2);
        check("outstanding drained", 32'(outst2), 32'd0);

        // Forwarding, then a later write must not disturb the in-flight response.
        wr2(32'h0001_0010, 32'hCAFE_0001); rd2_op(32'h0001_0010); tick();
        wr2(32'h0001_0010, 32'h5555_AAAA); tick();
        repeat (3) tick();
        rd2_op(32'h0001_0010); tick();
        rd2_op(32'h0001_0043); tick();
        rd2_op(32'h0001_0FFC); tick();
        repeat (3) tick();

        // Out-of-range accesses.
        rd2_op(32'h0000_FFFC); tick();
        check("oor read err pulse", 32'(err2), 32'd1);
        check("oor read err_count", 32'(errc2), 32'd1);
        tick();
        check("err pulse ends", 32'(err2), 32'd0);
        wr2(32'h0001_1000, 32'hBAD0_BAD0); tick();
        check("oor write err pulse", 32'(err2), 32'd1);
        check("oor write err_count", 32'(errc2), 32'd2);
        rd2_op(BASE); tick();
        check("in-range read no err", 32'(err2), 32'd0);
        wr2(32'h0000_0000, 32'h0000_0001); rd2_op(32'hFFFF_FFFC); tick();
        check("dual oor err pulse", 32'(err2), 32'd1);
        check("dual oor err_count", 32'(errc2), 32'd4);
        repeat (4) tick();
        check("dut2 queue drained", 32'(q2.size()), 32'd0);

        // LATENCY=4: reset kills an in-flight read, store survives, reset-time write ignored.
        wr4(32'h0001_0080, 32'hA5A5_0080); tick();
        rd4_op(32'h0001_0080); tick();
        rst_n = 1'b0;
        wr_en4 = 1'b1; wr_addr4 = 32'h0001_0080; wr_data4 = 32'hFFFF_0000;
        q4.delete();
        tick();
        check("dut4 outstanding after reset", 32'(outst4), 32'd0);
        tick();
        rst_n = 1'b1;
        check("dut2 err_count after reset", 32'(errc2), 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("dut4 no resp after reset", 32'(rv4), 32'd0);
        end
        rd4_op(32'h0001_0080); tick();
        repeat (6) tick();
        check("dut4 queue drained", 32'(q4.size()), 32'd0);
        check("dut4 outstanding drained", 32'(outst4), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
